// File: rtl/avalon_byte_mem_responder.sv
// Avalon-MM byte RAM responder for the RSA core's byte-wide master port.
// It has a programmable number of wait states, an address window check,
// saturating access counters and a sticky protocol-error flag.
module avalon_byte_mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_LOG2  = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        avs_waitrequest,
    input  logic [31:0] avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    output logic [7:0]  avs_readdata,
    input  logic [7:0]  avs_writedata,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] oor_count,
    output logic        proto_err
);

    localparam int          DEPTH         = 1 << DEPTH_LOG2;
    localparam logic [32:0] WINDOW        = 33'(1) << DEPTH_LOG2;
    localparam logic [3:0]  WAIT_CNT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t state;
    state_t state_nxt;
    logic [3:0] wait_cnt;

    logic [7:0] mem [DEPTH];

    logic [31:0]           offset;
    logic                  in_window;
    logic [DEPTH_LOG2-1:0] index;
    logic                  req;

    // Request captured in IDLE; the access completes in ACK.
    logic       req_win_p1;
    logic       req_wr_p1;
    logic [7:0] ram_rdata_p1;
    logic [7:0] ack_rdata;
    logic [7:0] readdata_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Offset wraps modulo 2**32, so addresses below the base fail the first term.
    assign offset    = avs_address - ADDR_BASE;
    assign in_window = (avs_address >= ADDR_BASE) && ({1'b0, offset} < WINDOW);
    assign index     = offset[DEPTH_LOG2-1:0];
    assign req       = avs_read | avs_write;

    assign avs_waitrequest = (state != S_ACK);
    assign ack_rdata       = req_win_p1 ? ram_rdata_p1 : FILL_BYTE;
    // Live RAM/fill byte during a read ACK; otherwise hold the last returned byte.
    assign avs_readdata    = (state == S_ACK && !req_wr_p1) ? ack_rdata : readdata_q;

    // Next-state logic: wait-state countdown, abort on dropped request, single-cycle ACK.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (wait_cnt == 4'd1) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control state: FSM, wait counter, counters, sticky error and held read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= 4'd0;
            rd_count   <= 16'd0;
            wr_count   <= 16'd0;
            oor_count  <= 16'd0;
            proto_err  <= 1'b0;
            readdata_q <= 8'h00;
        end else begin
            state <= state_nxt;
            if (avs_read && avs_write) begin
                proto_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (req) begin
                        wait_cnt <= WAIT_CNT_INIT;
                    end
                end
                S_WAIT: wait_cnt <= wait_cnt - 4'd1;
                S_ACK: begin
                    if (req_wr_p1) begin
                        wr_count <= sat_inc(wr_count);
                    end else begin
                        rd_count   <= sat_inc(rd_count);
                        readdata_q <= ack_rdata;
                    end
                    if (!req_win_p1) begin
                        oor_count <= sat_inc(oor_count);
                    end
                end
                default: ;
            endcase
        end
    end

    // Request capture: window flag, op type (read+write counts as write) and registered RAM read.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            req_win_p1   <= in_window;
            req_wr_p1    <= avs_write;
            ram_rdata_p1 <= mem[index];
        end
    end

    // RAM write in ACK using the re-sampled address and data; never under reset.
    always_ff @(posedge clk) begin
        if (!reset && state == S_ACK && req_wr_p1 && req_win_p1) begin
            mem[index] <= avs_writedata;
        end
    end

endmodule
